// File: rtl/prog_loader_if.sv
// Bus between a program source and the loader: start pulse, byte stream
// in, instruction-memory write port and core/status signals out.
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              core_resetn;
  logic              busy;
  logic              done;
  logic              err;

  // Program source side: drives the stream, observes the loader.
  modport master (
    output start, s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data, core_resetn, busy, done, err
  );

  // Loader side.
  modport slave (
    input  start, s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data, core_resetn, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a length byte, N instruction words and a
// checksum byte over a valid/ready stream, writes the words to instruction
// memory and holds the core in reset until a load completes cleanly.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           reset,
  prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  localparam int unsigned               DEPTH     = 2 ** ADDR_W;
  localparam logic [DATA_W+ADDR_W:0]    DEPTH_EXT = (DATA_W + ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]           ONE       = (ADDR_W + 1)'(1);

  state_t              state_q, state_d;
  // addr_q is one bit wider than the memory address so it doubles as the
  // byte count and can reach N = DEPTH without wrapping.
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                s_ready_q, busy_q, done_q, err_q, core_q;

  logic                accept;
  logic [DATA_W+ADDR_W:0] len_ext;
  logic                len_ok;

  assign accept  = bus.s_valid & s_ready_q;
  assign len_ext = {{(ADDR_W + 1){1'b0}}, bus.s_data};
  assign len_ok  = (len_ext != '0) && (len_ext <= DEPTH_EXT);

  // Next-state and datapath update for the load sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d = LEN;
          addr_d  = '0;
          len_d   = '0;
          sum_d   = '0;
        end
      end
      LEN: begin
        if (accept) begin
          if (len_ok) begin
            state_d = DATA;
            len_d   = len_ext[ADDR_W:0];
          end else begin
            state_d = ERR;
          end
        end
      end
      DATA: begin
        if (accept) begin
          addr_d = addr_q + ONE;
          sum_d  = sum_q + bus.s_data;
          if ((addr_q + ONE) == len_q) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (bus.s_data == sum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and status outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      core_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      s_ready_q <= state_d inside {LEN, DATA, CSUM};
      busy_q    <= state_d inside {LEN, DATA, CSUM};
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERR);
      core_q    <= (state_d == IDLE) || (state_d == DONE);
    end
  end

  // Writes are combinational so each word lands in the cycle it arrives.
  assign bus.wr_en   = (state_q == DATA) && accept;
  assign bus.wr_addr = bus.wr_en ? addr_q[ADDR_W-1:0] : '0;
  assign bus.wr_data = bus.wr_en ? bus.s_data : '0;

  assign bus.s_ready     = s_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  // The core is held in reset while the loader itself is in reset.
  assign bus.core_resetn = core_q & ~reset;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a stream-parsing model predicts the
// outputs every cycle, an emulated instruction memory captures the writes.
module tb_prog_loader;

  localparam int ST_IDLE = 0;
  localparam int ST_LOAD = 1;
  localparam int ST_DONE = 2;
  localparam int ST_ERR  = 3;

  logic clk;
  logic reset;

  int checkCount = 0;
  int errorCount = 0;

  prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated instruction memory written by the DUT.
  logic [7:0] imem [16] = '{default: 8'hEE};
  always @(posedge clk) begin
    if (bus.wr_en) imem[bus.wr_addr] <= bus.wr_data;
  end

  // Model state: whether a load was ever started and the bytes accepted.
  bit         started = 1'b0;
  logic [7:0] rxQ [$];
  logic [7:0] memModel [16] = '{default: 8'hEE};

  // Interpret the accepted byte stream as length, payload and checksum.
  function automatic int classify();
    int n;
    logic [7:0] s;
    if (rxQ.size() == 0) return ST_LOAD;
    n = int'(rxQ[0]);
    if (n == 0 || n > 16) return ST_ERR;
    if (rxQ.size() < n + 2) return ST_LOAD;
    s = 8'h00;
    for (int i = 1; i <= n; i++) s = s + rxQ[i];
    return (s == rxQ[n+1]) ? ST_DONE : ST_ERR;
  endfunction

  function automatic int modelStatus();
    return started ? classify() : ST_IDLE;
  endfunction

  function automatic bit modelBusy();
    return modelStatus() == ST_LOAD;
  endfunction

  // A payload byte is expected to be written when it is offered.
  function automatic bit expWr();
    return !reset && modelBusy() && bus.s_valid && rxQ.size() >= 1
           && rxQ.size() <= int'(rxQ[0]);
  endfunction

  // Model update on each clock edge; reset aborts any load.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      started = 1'b0;
      rxQ.delete();
    end else if (bus.start && !modelBusy()) begin
      started = 1'b1;
      rxQ.delete();
    end else if (modelBusy() && bus.s_valid) begin
      if (expWr()) memModel[rxQ.size()-1] = bus.s_data;
      rxQ.push_back(bus.s_data);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int  st;
    bit  w;
    st = modelStatus();
    w  = expWr();
    if (reset) begin
      checkOutput("rst_s_ready", 32'(bus.s_ready), 0);
      checkOutput("rst_busy",    32'(bus.busy), 0);
      checkOutput("rst_done",    32'(bus.done), 0);
      checkOutput("rst_err",     32'(bus.err), 0);
      checkOutput("rst_core",    32'(bus.core_resetn), 0);
      checkOutput("rst_wr_en",   32'(bus.wr_en), 0);
      checkOutput("rst_wr_addr", 32'(bus.wr_addr), 0);
      checkOutput("rst_wr_data", 32'(bus.wr_data), 0);
    end else begin
      checkOutput("cyc_s_ready", 32'(bus.s_ready), 32'(st == ST_LOAD));
      checkOutput("cyc_busy",    32'(bus.busy), 32'(st == ST_LOAD));
      checkOutput("cyc_done",    32'(bus.done), 32'(st == ST_DONE));
      checkOutput("cyc_err",     32'(bus.err), 32'(st == ST_ERR));
      checkOutput("cyc_core",    32'(bus.core_resetn),
                  32'(st == ST_IDLE || st == ST_DONE));
      checkOutput("cyc_wr_en",   32'(bus.wr_en), 32'(w));
      if (w) begin
        checkOutput("cyc_wr_addr", 32'(bus.wr_addr), 32'(rxQ.size() - 1));
        checkOutput("cyc_wr_data", 32'(bus.wr_data), 32'(bus.s_data));
      end
    end
  end

  // Drive one cycle of inputs, then settle just after the edge.
  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d);
    bus.start   = st;
    bus.s_valid = v;
    bus.s_data  = d;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
  endtask

  task automatic checkMemory(input string tag);
    for (int i = 0; i < 16; i++) checkOutput({tag, "_mem"}, 32'(imem[i]), 32'(memModel[i]));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, expected end before 100000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("lit_reset_busy", 32'(bus.busy), 0);
    checkOutput("lit_reset_core", 32'(bus.core_resetn), 0);
    reset = 1'b0;
    #1;
    checkOutput("lit_idle_core", 32'(bus.core_resetn), 1);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] basic load 03 A1 52 07 FA");
    applyStimulus(1, 0, 8'h00);
    checkOutput("lit039_core_low", 32'(bus.core_resetn), 0);
    applyStimulus(0, 1, 8'h03);
    applyStimulus(0, 1, 8'hA1);
    applyStimulus(0, 1, 8'h52);
    applyStimulus(0, 1, 8'h07);
    applyStimulus(0, 1, 8'hFA);
    checkOutput("lit039_done", 32'(bus.done), 1);
    checkOutput("lit039_core", 32'(bus.core_resetn), 1);
    applyStimulus(0, 0, 8'h00);
    checkOutput("lit039_m0", 32'(imem[0]), 32'h A1);
    checkOutput("lit039_m2", 32'(imem[2]), 32'h07);
    checkOutput("lit039_m3", 32'(imem[3]), 32'hEE);
    checkMemory("s039");

    $display("[TB] bad checksum, start with s_valid in DONE");
    applyStimulus(1, 1, 8'h02);
    applyStimulus(0, 1, 8'h02);
    applyStimulus(0, 1, 8'h10);
    applyStimulus(0, 1, 8'h20);
    applyStimulus(0, 1, 8'h00);
    checkOutput("lit040_err",  32'(bus.err), 1);
    checkOutput("lit040_done", 32'(bus.done), 0);
    checkOutput("lit040_core", 32'(bus.core_resetn), 0);
    applyStimulus(0, 0, 8'h00);
    checkOutput("lit040_m1", 32'(imem[1]), 32'h20);
    checkMemory("s040");

    $display("[TB] zero and oversize length");
    applyStimulus(1, 0, 8'h00);
    checkOutput("lit041_err_clr", 32'(bus.err), 0);
    applyStimulus(0, 1, 8'h00);
    checkOutput("lit041a_err", 32'(bus.err), 1);
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 1, 8'h11);
    checkOutput("lit041b_err", 32'(bus.err), 1);
    applyStimulus(0, 0, 8'h00);
    checkMemory("s041");

    $display("[TB] full depth load, start while busy");
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 1, 8'h10);
    for (int i = 0; i < 16; i++) applyStimulus(i == 5, 1, 8'(i));
    applyStimulus(0, 1, 8'h78);
    checkOutput("lit042_done", 32'(bus.done), 1);
    applyStimulus(0, 0, 8'h00);
    checkOutput("lit042_m15", 32'(imem[15]), 32'h0F);
    checkOutput("lit042_m0",  32'(imem[0]), 32'h00);
    checkMemory("s042");

    $display("[TB] stalled stream");
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 1, 8'h03);
    applyStimulus(0, 1, 8'hA1);
    repeat (5) applyStimulus(0, 0, 8'hFF);
    checkOutput("lit043_busy", 32'(bus.busy), 1);
    applyStimulus(0, 1, 8'h52);
    applyStimulus(0, 1, 8'h07);
    applyStimulus(0, 1, 8'hFA);
    checkOutput("lit043_done", 32'(bus.done), 1);
    applyStimulus(0, 0, 8'h00);
    checkOutput("lit043_m1", 32'(imem[1]), 32'h52);
    checkOutput("lit043_m3", 32'(imem[3]), 32'h03);
    checkMemory("s043");

    $display("[TB] reset mid-load");
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 1, 8'h03);
    applyStimulus(0, 1, 8'h5A);
    bus.s_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("lit044_busy",    32'(bus.busy), 0);
    checkOutput("lit044_s_ready", 32'(bus.s_ready), 0);
    checkOutput("lit044_core",    32'(bus.core_resetn), 0);
    checkOutput("lit044_wr_en",   32'(bus.wr_en), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("lit044_core_rel", 32'(bus.core_resetn), 1);
    checkOutput("lit044_m0", 32'(imem[0]), 32'h5A);
    checkOutput("lit044_m1", 32'(imem[1]), 32'h52);
    applyStimulus(0, 0, 8'h00);
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 1, 8'h02);
    applyStimulus(0, 1, 8'h11);
    applyStimulus(0, 1, 8'h22);
    applyStimulus(0, 1, 8'h33);
    checkOutput("lit044_done", 32'(bus.done), 1);
    applyStimulus(0, 0, 8'h00);
    checkOutput("lit044_m0b", 32'(imem[0]), 32'h11);
    checkOutput("lit044_m2",  32'(imem[2]), 32'h07);
    checkMemory("s044");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
